// File: rtl/axi_sched_pkg.sv
// rtl/axi_sched_pkg.sv - shared constants for the AXI transaction scheduler
package axi_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ADDR  = 3'd1;
    localparam state_t S_WDATA = 3'd2;
    localparam state_t S_WRESP = 3'd3;
    localparam state_t S_RDATA = 3'd4;

    // Fixed burst attributes, tied off at integration.
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_DW    = 3'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal rotating pointer
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;

    // Pick the first requester at or after ptr, wrapping; the next pointer is one past it.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = PW'((idx + 1) % NREQ);
            end
        end
    end

    // Advance the pointer only when the grant is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/axi_txn_scheduler.sv
// rtl/axi_txn_scheduler.sv - shares one AXI4 master between NREQ requesters, one burst at a time
module axi_txn_scheduler
    import axi_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_len,
    output logic [NREQ-1:0]   gnt,
    input  logic [DW-1:0]     wd_data,
    input  logic              wd_valid,
    output logic              wd_ready,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic [NREQ-1:0]   done,
    output logic [1:0]        err,
    output logic [AW-1:0]     m_awaddr,
    output logic [7:0]        m_awlen,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [AW-1:0]     m_araddr,
    output logic [7:0]        m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [DW-1:0]     m_wdata,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [DW-1:0]     m_rdata,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    state_t          state;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [7:0]      cnt;
    logic [7:0]      cnt_inc;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [7:0]      sel_len;
    logic            in_wdata;
    logic            in_rdata;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (accept),
        .grant (grant)
    );

    assign accept    = (state == S_IDLE) && (|req_valid) && !rst;
    assign req_ready = accept ? grant : '0;

    // Mux the winning requester's command fields using the one-hot grant.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_len   = req_len[i*8 +: 8];
            end
        end
    end

    // The beat counter saturates so an over-long read waiting for rlast cannot alias a short len.
    assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign in_wdata = (state == S_WDATA);
    assign in_rdata = (state == S_RDATA);

    assign m_awaddr  = cmd_addr;
    assign m_awlen   = cmd_len;
    assign m_awvalid = (state == S_ADDR) && cmd_write;
    assign m_araddr  = cmd_addr;
    assign m_arlen   = cmd_len;
    assign m_arvalid = (state == S_ADDR) && !cmd_write;

    assign m_wdata   = in_wdata ? wd_data : '0;
    assign m_wvalid  = in_wdata && wd_valid;
    assign wd_ready  = in_wdata && m_wready;
    assign m_wlast   = in_wdata && (cnt == cmd_len);

    assign m_bready  = (state == S_WRESP);

    assign m_rready  = in_rdata;
    assign rd_valid  = in_rdata && m_rvalid;
    assign rd_data   = in_rdata ? m_rdata : '0;

    // Burst sequencer: accept, address phase, data beats, response, then back to IDLE with a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= RESP_OKAY;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_write <= sel_write;
                        cmd_addr  <= sel_addr;
                        cmd_len   <= sel_len;
                        gnt       <= grant;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (cmd_write && m_awready) begin
                        cnt   <= '0;
                        state <= S_WDATA;
                    end else if (!cmd_write && m_arready) begin
                        cnt   <= '0;
                        state <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (m_wvalid && m_wready) begin
                        cnt <= cnt_inc;
                        if (cnt == cmd_len) begin
                            state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (m_bvalid) begin
                        err   <= m_bresp;
                        done  <= gnt;
                        gnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (m_rvalid) begin
                        cnt <= cnt_inc;
                        if (m_rlast) begin
                            err   <= (cnt == cmd_len) ? RESP_OKAY : RESP_SLVERR;
                            done  <= gnt;
                            gnt   <= '0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// tb/tb_axi_txn_scheduler.sv - directed self-checking bench for axi_txn_scheduler
module tb_axi_txn_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_write, gnt, done;
    logic [63:0] req_addr;
    logic [15:0] req_len;
    logic [63:0] wd_data, rd_data, m_wdata, m_rdata;
    logic        wd_valid, wd_ready, rd_valid;
    logic [1:0]  err, m_bresp;
    logic [31:0] m_awaddr, m_araddr;
    logic [7:0]  m_awlen, m_arlen;
    logic        m_awvalid, m_awready, m_arvalid, m_arready;
    logic        m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_rlast, m_rvalid, m_rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_txn_scheduler #(.NREQ(2), .AW(32), .DW(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .gnt(gnt),
        .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        wd_data = '0; wd_valid = 0; m_awready = 0; m_arready = 0; m_wready = 0;
        m_bresp = '0; m_bvalid = 0; m_rdata = '0; m_rlast = 0; m_rvalid = 0;
    endtask

    // Plays requester + AXI slave for one write burst and reports what it observed.
    task automatic run_write(input int idx, input logic [31:0] addr, input logic [7:0] len,
                             input logic [63:0] base, input logic [1:0] bresp,
                             input int aw_stall, input bit toggle,
                             output logic [1:0] rdy_seen, output logic [1:0] gnt_seen,
                             output int aw_hs, output int beats, output int wlast_bad,
                             output int bad, output logic [1:0] done_seen,
                             output logic [1:0] err_seen);
        int beat;
        int cyc;
        aw_hs = 0; beats = 0; wlast_bad = 0; bad = 0;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_write[idx] = 1'b1;
        req_addr[idx*32 +: 32] = addr;
        req_len[idx*8 +: 8] = len;
        #1 rdy_seen = req_ready;
        tick();
        req_valid = '0;
        gnt_seen = gnt;
        for (int s = 0; s < aw_stall; s++) begin
            m_awready = 0;
            #1;
            if (m_awvalid !== 1'b1 || m_awaddr !== addr || m_awlen !== len) bad++;
            tick();
        end
        m_awready = 1;
        #1;
        if (m_awvalid === 1'b1) aw_hs++;
        if (m_awaddr !== addr || m_awlen !== len) bad++;
        tick();
        m_awready = 0;
        beat = 0;
        cyc = 0;
        while (beat <= int'(len) && cyc < 2000) begin
            wd_valid = 1;
            wd_data = base + 64'(beat);
            m_wready = toggle ? cyc[0] : 1'b1;
            #1;
            if (m_awvalid === 1'b1) aw_hs++;
            if (m_wvalid !== 1'b1 || m_wdata !== wd_data || wd_ready !== m_wready) bad++;
            if (m_wlast !== (beat == int'(len))) wlast_bad++;
            if (m_wvalid && m_wready) beat++;
            tick();
            cyc++;
        end
        if (cyc >= 2000) bad++;
        beats = beat;
        // Response phase: bvalid comes one cycle late; any W beat here is an extra beat.
        wd_valid = 1; m_wready = 1;
        #1;
        if (m_wvalid === 1'b1) beats++;
        if (m_bready !== 1'b1) bad++;
        tick();
        wd_valid = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = bresp;
        tick();
        m_bvalid = 0; m_bresp = '0;
        #1;
        done_seen = done;
        err_seen = err;
        if (gnt !== 2'b00) bad++;
    endtask

    // Plays requester + AXI slave for one read burst, ending it with rlast on beat rlast_beat.
    task automatic run_read(input int idx, input logic [31:0] addr, input logic [7:0] len,
                            input int rlast_beat,
                            output logic [1:0] rdy_seen, output logic [1:0] gnt_seen,
                            output int ar_hs, output int rd_beats, output int bad,
                            output logic [1:0] done_seen, output logic [1:0] err_seen);
        ar_hs = 0; rd_beats = 0; bad = 0;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_write[idx] = 1'b0;
        req_addr[idx*32 +: 32] = addr;
        req_len[idx*8 +: 8] = len;
        #1 rdy_seen = req_ready;
        tick();
        req_valid = '0;
        gnt_seen = gnt;
        m_arready = 1;
        #1;
        if (m_arvalid === 1'b1 && m_araddr === addr && m_arlen === len) ar_hs++;
        tick();
        m_arready = 0;
        for (int b = 0; b <= rlast_beat; b++) begin
            m_rvalid = 1;
            m_rdata = 64'hA5A5_0000_0000_0000 | 64'(b);
            m_rlast = (b == rlast_beat);
            #1;
            if (m_arvalid === 1'b1) bad++;
            if (rd_valid === 1'b1 && rd_data === m_rdata && m_rready === 1'b1) rd_beats++;
            tick();
        end
        m_rvalid = 0; m_rlast = 0; m_rdata = '0;
        #1;
        done_seen = done;
        err_seen = err;
        if (gnt !== 2'b00 || rd_valid !== 1'b0) bad++;
    endtask

    task automatic apply_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        checks++;
        if ({gnt, done, err, req_ready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: gnt=%b done=%b err=%b req_ready=%b expected all 0", gnt, done, err, req_ready);
        end
        checks++;
        if ({m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready, wd_ready, rd_valid, m_wlast} !== 8'h00) begin
            errors++;
            $display("FAIL reset_handshakes: got %b expected 00000000",
                     {m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready, wd_ready, rd_valid, m_wlast});
        end
        rst = 0;
        tick();
    endtask

    task automatic test_write_basic();
        logic [1:0] rdy, g, d, e;
        int aw, beats, wl, bad;
        run_write(0, 32'h100, 8'd3, 64'd1, 2'b00, 0, 1'b0, rdy, g, aw, beats, wl, bad, d, e);
        checks++;
        if (rdy !== 2'b01 || g !== 2'b01) begin
            errors++;
            $display("FAIL wr_grant: ready=%b gnt=%b expected 01/01", rdy, g);
        end
        checks++;
        if (aw !== 1 || beats !== 4 || wl !== 0 || bad !== 0) begin
            errors++;
            $display("FAIL wr_beats: aw=%0d beats=%0d wlast_bad=%0d bad=%0d expected 1/4/0/0", aw, beats, wl, bad);
        end
        checks++;
        if (d !== 2'b01 || e !== 2'b00) begin
            errors++;
            $display("FAIL wr_done: done=%b err=%b expected 01/00", d, e);
        end
        tick();
        checks++;
        if (done !== 2'b00) begin
            errors++;
            $display("FAIL wr_done_pulse: done=%b expected 00", done);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        apply_reset();
        req_valid = 2'b11; req_write = 2'b00; req_len = '0;
        req_addr = {32'h2000, 32'h1000};
        for (int n = 0; n < 4; n++) begin
            exp = (n % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (req_ready !== exp) begin
                errors++;
                $display("FAIL rr_ready_%0d: got %b expected %b", n, req_ready, exp);
            end
            tick();
            checks++;
            if (gnt !== exp || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL rr_gnt_%0d: gnt=%b ready=%b expected %b/00", n, gnt, req_ready, exp);
            end
            m_arready = 1;
            tick();
            m_arready = 0;
            m_rvalid = 1; m_rlast = 1;
            tick();
            m_rvalid = 0; m_rlast = 0;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_read_single();
        logic [1:0] rdy, g, d, e;
        int ar, rb, bad;
        run_read(1, 32'h4000, 8'd0, 0, rdy, g, ar, rb, bad, d, e);
        checks++;
        if (rdy !== 2'b10 || g !== 2'b10 || ar !== 1) begin
            errors++;
            $display("FAIL rd1_addr: ready=%b gnt=%b ar=%0d expected 10/10/1", rdy, g, ar);
        end
        checks++;
        if (rb !== 1 || bad !== 0 || d !== 2'b10 || e !== 2'b00) begin
            errors++;
            $display("FAIL rd1_done: beats=%0d bad=%0d done=%b err=%b expected 1/0/10/00", rb, bad, d, e);
        end
    endtask

    task automatic test_errors();
        logic [1:0] rdy, g, d, e;
        int ar, rb, bad, aw, beats, wl;
        run_read(0, 32'h5000, 8'd3, 2, rdy, g, ar, rb, bad, d, e);
        checks++;
        if (rb !== 3 || d !== 2'b01 || e !== 2'b10 || bad !== 0) begin
            errors++;
            $display("FAIL rd_short: beats=%0d done=%b err=%b bad=%0d expected 3/01/10/0", rb, d, e, bad);
        end
        run_write(1, 32'h6000, 8'd1, 64'h50, 2'b10, 0, 1'b0, rdy, g, aw, beats, wl, bad, d, e);
        checks++;
        if (beats !== 2 || d !== 2'b10 || e !== 2'b10 || bad !== 0) begin
            errors++;
            $display("FAIL wr_slverr: beats=%0d done=%b err=%b bad=%0d expected 2/10/10/0", beats, d, e, bad);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] rdy, g, d, e;
        int aw, beats, wl, bad;
        run_write(0, 32'h2000, 8'd3, 64'hC0DE_0000, 2'b00, 5, 1'b1, rdy, g, aw, beats, wl, bad, d, e);
        checks++;
        if (aw !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL bp_stable: aw=%0d bad=%0d expected 1/0", aw, bad);
        end
        checks++;
        if (beats !== 4 || wl !== 0 || d !== 2'b01) begin
            errors++;
            $display("FAIL bp_beats: beats=%0d wlast_bad=%0d done=%b expected 4/0/01", beats, wl, d);
        end
    endtask

    task automatic test_len_255();
        logic [1:0] rdy, g, d, e;
        int aw, beats, wl, bad;
        run_write(1, 32'h8000, 8'd255, 64'h9000, 2'b00, 0, 1'b0, rdy, g, aw, beats, wl, bad, d, e);
        checks++;
        if (beats !== 256 || wl !== 0 || bad !== 0 || d !== 2'b10 || e !== 2'b00) begin
            errors++;
            $display("FAIL len255: beats=%0d wlast_bad=%0d bad=%0d done=%b err=%b expected 256/0/0/10/00",
                     beats, wl, bad, d, e);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] rdy, g, d, e;
        int aw, beats, wl, bad;
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[31:0] = 32'h700; req_len[7:0] = 8'd7;
        tick();
        req_valid = '0;
        m_awready = 1;
        tick();
        m_awready = 0;
        wd_valid = 1; m_wready = 1;
        wd_data = 64'h1; tick();
        wd_data = 64'h2; tick();
        wd_data = 64'h3;
        rst = 1;
        tick();
        checks++;
        if ({m_awvalid, m_arvalid, m_wvalid, wd_ready, m_bready, m_rready, rd_valid} !== 7'b0 ||
            gnt !== 2'b00 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid: valids=%b gnt=%b ready=%b expected 0/00/00",
                     {m_awvalid, m_arvalid, m_wvalid, wd_ready, m_bready, m_rready, rd_valid}, gnt, req_ready);
        end
        rst = 0;
        wd_valid = 0; m_wready = 0;
        tick();
        run_write(0, 32'h300, 8'd1, 64'hAB, 2'b00, 0, 1'b0, rdy, g, aw, beats, wl, bad, d, e);
        checks++;
        if (rdy !== 2'b01 || aw !== 1 || beats !== 2 || wl !== 0 || bad !== 0 || d !== 2'b01 || e !== 2'b00) begin
            errors++;
            $display("FAIL rst_recover: ready=%b aw=%0d beats=%0d wl=%0d bad=%0d done=%b err=%b",
                     rdy, aw, beats, wl, bad, d, e);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_round_robin();
        test_read_single();
        test_errors();
        test_backpressure();
        test_len_255();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
